// File: rtl/proc_trace_checker.sv
// Expected-vector result checker for processor bring-up: compares NUM_CH observed
// buses per sample against a loaded vector memory, counting and recording mismatches.

module proc_trace_lane #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] obs,
    input  logic [DATA_W-1:0] exp_val,
    input  logic              mask,
    output logic              mis
);
    // Case-inequality so X/Z on an observed bus is flagged in simulation.
    assign mis = mask & (obs !== exp_val);
endmodule

module proc_trace_checker #(
    parameter int DATA_W      = 32,
    parameter int NUM_CH      = 2,
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int STOP_ON_ERR = 0,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_en,
    input  logic [ADDR_W-1:0]        load_addr,
    input  logic [NUM_CH*DATA_W-1:0] load_data,
    input  logic [NUM_CH-1:0]        load_mask,
    input  logic [ADDR_W-1:0]        num_vec,
    input  logic                     start,
    input  logic                     sample_en,
    input  logic [NUM_CH*DATA_W-1:0] obs_data,
    output logic                     running,
    output logic                     done,
    output logic                     error_flag,
    output logic [CNT_W-1:0]         err_count,
    output logic [ADDR_W-1:0]        vec_num,
    output logic [ADDR_W-1:0]        first_err_idx,
    output logic [NUM_CH-1:0]        first_err_ch
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    typedef struct packed {
        logic [NUM_CH-1:0]             mask;
        logic [NUM_CH-1:0][DATA_W-1:0] data;
    } vec_t;

    state_t            state, state_d;
    vec_t              mem [DEPTH];
    vec_t              rd_vec;
    logic [NUM_CH-1:0] mis;
    logic [ADDR_W-1:0] last_idx, last_idx_d;
    logic              stg_vld;
    logic [ADDR_W-1:0] stg_idx;
    logic [NUM_CH-1:0] stg_mis;
    logic              do_load, do_start, accept, stg_err, stop_now;

    assign do_load  = (state == S_IDLE) && load_en;
    assign do_start = start && (((state == S_IDLE) && !load_en) || (state == S_DONE));
    assign accept   = (state == S_RUN) && sample_en;
    assign stg_err  = stg_vld && (|stg_mis);
    assign stop_now = (STOP_ON_ERR != 0) && stg_err;

    assign running  = (state == S_RUN) || (state == S_FLUSH);
    assign done     = (state == S_DONE);

    always_comb begin
        last_idx_d = num_vec;
        if (int'(num_vec) >= DEPTH)
            last_idx_d = ADDR_W'(DEPTH - 1);
    end

    always_ff @(posedge clk) begin
        if (do_load && (int'(load_addr) < DEPTH))
            mem[load_addr] <= {load_mask, load_data};
    end

    assign rd_vec = mem[vec_num];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        proc_trace_lane #(.DATA_W(DATA_W)) u_lane (
            .obs     (obs_data[k*DATA_W +: DATA_W]),
            .exp_val (rd_vec.data[k]),
            .mask    (rd_vec.mask[k]),
            .mis     (mis[k])
        );
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (do_start) state_d = S_RUN;
            S_RUN: begin
                if (stop_now)
                    state_d = S_DONE;
                else if (accept && (vec_num == last_idx))
                    state_d = S_FLUSH;
            end
            // Stays until the compare stage of the final sample has retired.
            S_FLUSH: if (stop_now || !stg_vld) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            last_idx      <= '0;
            stg_vld       <= 1'b0;
            stg_idx       <= '0;
            stg_mis       <= '0;
            vec_num       <= '0;
            err_count     <= '0;
            error_flag    <= 1'b0;
            first_err_idx <= '0;
            first_err_ch  <= '0;
        end else begin
            state   <= state_d;
            // A sample landing in the same cycle as a stopping error is dropped.
            stg_vld <= accept && !stop_now;
            if (accept) begin
                stg_idx <= vec_num;
                stg_mis <= mis;
            end
            if (do_start) begin
                last_idx      <= last_idx_d;
                vec_num       <= '0;
                err_count     <= '0;
                error_flag    <= 1'b0;
                first_err_idx <= '0;
                first_err_ch  <= '0;
            end else begin
                if (accept)
                    vec_num <= vec_num + 1'b1;
                if (stg_err) begin
                    if (err_count != {CNT_W{1'b1}})
                        err_count <= err_count + 1'b1;
                    error_flag <= 1'b1;
                    if (!error_flag) begin
                        first_err_idx <= stg_idx;
                        first_err_ch  <= stg_mis;
                    end
                end
            end
        end
    end
endmodule
